buf_ptr_ctrl: RTL and testbench

BUF_PTR_CTRL -- requirements
Module: buf_ptr_ctrl

---
 rtl/buf_ptr_ctrl_if.sv | 34 +++
 rtl/buf_ptr_ctrl.sv | 83 ++++++++
 tb/tb_buf_ptr_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/buf_ptr_ctrl_if.sv
// Handshake and pointer bundle between the operand producer, the MAC consumer
// and the buffer pointer controller.
interface buf_ptr_ctrl_if #(
   parameter int BufferWidth = 2
);
   // Valid/ready: a word moves only in a cycle where valid and ready are both high.
   // valid must not depend on ready; ready may depend on valid.
   logic                   in_valid;
   logic                   in_ready;
   logic                   out_valid;
   logic                   out_ready;
   logic                   flush;
   logic                   wr_en;
   logic [BufferWidth-1:0] wr_ptr;
   logic [BufferWidth-1:0] rd_ptr;
   logic [BufferWidth:0]   count;
   logic                   full;
   logic                   empty;
   logic                   flush_busy;
   // Debug view of the controller state: 0 = IDLE, 1 = ACTIVE, 2 = FLUSH.
   logic [1:0]             state_dbg;

   modport master (
      output in_valid, out_ready, flush,
      input  in_ready, out_valid, wr_en, wr_ptr, rd_ptr, count,
             full, empty, flush_busy, state_dbg
   );

   modport slave (
      input  in_valid, out_ready, flush,
      output in_ready, out_valid, wr_en, wr_ptr, rd_ptr, count,
             full, empty, flush_busy, state_dbg
   );
endinterface

// File: rtl/buf_ptr_ctrl.sv
// Read/write pointer and occupancy controller for a 2^BufferWidth-entry operand
// buffer feeding a MAC, with a one-cycle flush state.
module buf_ptr_ctrl #(
   parameter int BufferWidth = 2
) (
   input  logic          clk,
   input  logic          rst,
   buf_ptr_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   localparam logic [BufferWidth:0] Depth = {1'b1, {BufferWidth{1'b0}}};

   state_t                 state;
   logic [BufferWidth-1:0] wr_ptr;
   logic [BufferWidth-1:0] rd_ptr;
   logic [BufferWidth:0]   count;
   logic [BufferWidth:0]   count_next;
   logic                   full;
   logic                   empty;
   logic                   in_ready;
   logic                   out_valid;
   logic                   push;
   logic                   pop;

   assign full      = (count == Depth);
   assign empty     = (count == '0);
   // rst gates in_ready so no write strobe can escape while reset is held.
   assign in_ready  = !rst && !full && !bus.flush && (state != FLUSH);
   assign out_valid = !empty && !bus.flush && (state != FLUSH);
   assign push      = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + (BufferWidth+1)'(1);
      end else if (pop && !push) begin
         count_next = count - (BufferWidth+1)'(1);
      end
   end

   // Pointers wrap for free because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         state  <= FLUSH;
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         case (state)
            FLUSH: begin
               state <= IDLE;
            end
            default: begin
               if (push) wr_ptr <= wr_ptr + BufferWidth'(1);
               if (pop)  rd_ptr <= rd_ptr + BufferWidth'(1);
               count <= count_next;
               state <= (count_next == '0) ? IDLE : ACTIVE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.wr_en      = push;
   assign bus.wr_ptr     = wr_ptr;
   assign bus.rd_ptr     = rd_ptr;
   assign bus.count      = count;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.flush_busy = (state == FLUSH);
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_buf_ptr_ctrl.sv
// Bench for buf_ptr_ctrl: directed vector table, async reset sequence and
// random traffic against a queue-based occupancy model.
module tb_buf_ptr_ctrl;
   localparam int BW = 2;
   localparam int D  = 1 << BW;

   logic clk;
   logic rst;

   buf_ptr_ctrl_if #(.BufferWidth(BW)) bus ();

   buf_ptr_ctrl #(.BufferWidth(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic iv;
      logic ordy;
      logic fl;
      logic e_ir;
      logic e_ov;
      logic e_we;
      int   e_wr;
      int   e_rd;
      int   e_cnt;
      int   e_st;
      logic e_fb;
   } vec_t;

   vec_t vecs[$];

   // Reference occupancy model: queue of the addresses holding live entries.
   int mq[$];
   int m_wr;
   int m_rd;
   bit m_flush;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input int wr, input int rd, input int cnt,
                             input int st, input logic fb);
      chk({tag, " wr_ptr"}, 32'(bus.wr_ptr), wr);
      chk({tag, " rd_ptr"}, 32'(bus.rd_ptr), rd);
      chk({tag, " count"}, 32'(bus.count), cnt);
      chk({tag, " full"}, 32'(bus.full), (cnt == D) ? 1 : 0);
      chk({tag, " empty"}, 32'(bus.empty), (cnt == 0) ? 1 : 0);
      chk({tag, " state"}, 32'(bus.state_dbg), st);
      chk({tag, " flush_busy"}, 32'(bus.flush_busy), 32'(fb));
   endtask

   task automatic add(input logic iv, input logic ordy, input logic fl,
                      input logic ir, input logic ov, input logic we,
                      input int wr, input int rd, input int cnt, input int st, input logic fb);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.fl = fl;
      v.e_ir = ir; v.e_ov = ov; v.e_we = we;
      v.e_wr = wr; v.e_rd = rd; v.e_cnt = cnt; v.e_st = st; v.e_fb = fb;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      bus.flush     = fl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      m_wr = 0;
      m_rd = 0;
      m_flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      //          iv ordy fl  ir ov we  wr rd cnt st fb
      // four pushes to full, then one refused push
      add(1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0);
      add(1, 0, 0, 1, 1, 1, 2, 0, 2, 1, 0);
      add(1, 0, 0, 1, 1, 1, 3, 0, 3, 1, 0);
      add(1, 0, 0, 1, 1, 1, 0, 0, 4, 1, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0, 4, 1, 0);
      // four pops to empty, then one refused pop
      add(0, 1, 0, 0, 1, 0, 0, 1, 3, 1, 0);
      add(0, 1, 0, 1, 1, 0, 0, 2, 2, 1, 0);
      add(0, 1, 0, 1, 1, 0, 0, 3, 1, 1, 0);
      add(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // fill to 2, then six simultaneous push/pop
      add(1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0);
      add(1, 0, 0, 1, 1, 1, 2, 0, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 3, 1, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 0, 2, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 1, 3, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 2, 0, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 3, 1, 2, 1, 0);
      add(1, 1, 0, 1, 1, 1, 0, 2, 2, 1, 0);
      // count 3, single-cycle flush with traffic offered
      add(1, 0, 0, 1, 1, 1, 1, 2, 3, 1, 0);
      add(1, 1, 1, 0, 0, 0, 1, 1, 0, 2, 1);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      add(1, 0, 0, 1, 0, 1, 2, 1, 1, 1, 0);
      // flush held for two cycles stays in FLUSH
      add(1, 0, 1, 0, 0, 0, 2, 2, 0, 2, 1);
      add(0, 0, 1, 0, 0, 0, 2, 2, 0, 2, 1);
      add(0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
      // push with pop offered at empty: no bypass
      add(1, 1, 0, 1, 0, 1, 3, 2, 1, 1, 0);

      // reset values while rst is held
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset", 0, 0, 0, 0, 1'b0);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset wr_en", 32'(bus.wr_en), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].e_we));
         @(posedge clk);
         #1;
         check_regs($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_cnt,
                    vecs[i].e_st, vecs[i].e_fb);
      end

      // asynchronous reset in the middle of a burst at count 3
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("burst count", 32'(bus.count), 3);
      #2;
      rst = 1'b1;
      #1;
      check_regs("async_rst", 0, 0, 0, 0, 1'b0);
      chk("async_rst out_valid", 32'(bus.out_valid), 0);
      chk("async_rst wr_en", 32'(bus.wr_en), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst in_ready", 32'(bus.in_ready), 1);
      chk("post_rst wr_en", 32'(bus.wr_en), 1);
      chk("post_rst wr_addr", 32'(bus.wr_ptr), 0);
      @(posedge clk);
      #1;
      check_regs("post_rst push", 1, 0, 1, 1, 1'b0);

      // random traffic against the occupancy model
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         logic iv, ordy, fl, e_ir, e_ov, e_push, e_pop;
         int   e_st;
         @(negedge clk);
         e_st = m_flush ? 2 : ((mq.size() == 0) ? 0 : 1);
         check_regs($sformatf("rnd%0d", n), m_wr, m_rd, mq.size(), e_st, m_flush);
         iv   = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         fl   = ($urandom_range(0, 19) == 0);
         drive(iv, ordy, fl);
         #1;
         e_ir   = (mq.size() < D) && !fl && !m_flush;
         e_ov   = (mq.size() > 0) && !fl && !m_flush;
         e_push = iv && e_ir;
         e_pop  = ordy && e_ov;
         chk($sformatf("rnd%0d in_ready", n), 32'(bus.in_ready), 32'(e_ir));
         chk($sformatf("rnd%0d out_valid", n), 32'(bus.out_valid), 32'(e_ov));
         chk($sformatf("rnd%0d wr_en", n), 32'(bus.wr_en), 32'(e_push));
         if (fl) begin
            mq.delete();
            m_rd    = m_wr;
            m_flush = 1'b1;
         end else begin
            m_flush = 1'b0;
            if (e_pop) begin
               void'(mq.pop_front());
               m_rd = (m_rd + 1) % D;
            end
            if (e_push) begin
               mq.push_back(m_wr);
               m_wr = (m_wr + 1) % D;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
